// File: rtl/ifu_resp_align_pkg.sv
// ifu_resp_align_pkg: shared FSM encoding and output-buffer entry layout {pc, inst, err}
package ifu_resp_align_pkg;
  typedef enum logic {ST_PASS = 1'b0, ST_DROP = 1'b1} state_e;
  // entry layout, LSB first: err at bit 0, inst above it, pc in the MSBs
  localparam int unsigned ERR_LSB = 0;
  localparam int unsigned INST_LSB = 1;
  function automatic int unsigned entry_w(int unsigned aw, int unsigned dw);
    return aw + dw + 1;
  endfunction
endpackage

// File: rtl/ifu_skid_buf.sv
// ifu_skid_buf: 2-entry FIFO output buffer with registered head
//   clk_i/rst_ni clock and async active-low reset; clr_i empties the buffer
//   wr_i/wdata_i push an entry; rd_i pops the head
//   rdata_o head entry; vld_o non-empty; full_o holds 2 entries
module ifu_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         wr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         rd_i,
  output logic [W-1:0] rdata_o,
  output logic         vld_o,
  output logic         full_o
);
  logic [1:0]   cnt_q, cnt_d, n;
  logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic         rd, wr;
  // n is the occupancy after this cycle's pop; a push lands in slot n,
  // so a push and a pop on a full buffer are both honoured
  always_comb begin
    rd = rd_i & (cnt_q != 2'd0);
    n = cnt_q - {1'b0, rd};
    wr = wr_i & (n != 2'd2);
    ent0_d = (wr && n == 2'd0) ? wdata_i : ((rd && cnt_q == 2'd2) ? ent1_q : ent0_q);
    ent1_d = (wr && n == 2'd1) ? wdata_i : ent1_q;
    cnt_d = clr_i ? 2'd0 : n + {1'b0, wr};
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end
  assign rdata_o = ent0_q;
  assign vld_o = cnt_q != 2'd0;
  assign full_o = cnt_q == 2'd2;
endmodule

// File: rtl/ifu_resp_align.sv
// ifu_resp_align: pairs bus fetch responses with request pcs and presents them to decode
//   i_clk/i_rstn clock and async active-low reset; i_flush pipeline redirect
//   i_req_fire request issued; i_rsp_* / o_rsp_rdy bus response handshake
//   i_fifo_addr/i_fifo_empty/o_fifo_ren request-address FIFO head and pop
//   o_dec_* / i_dec_rdy decode handshake; o_proto_err sticky protocol error
module ifu_resp_align
  import ifu_resp_align_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MAX_OUTST = 16
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_flush,
  input  logic              i_req_fire,
  input  logic              i_rsp_vld,
  input  logic [DATA_W-1:0] i_rsp_data,
  input  logic              i_rsp_err,
  output logic              o_rsp_rdy,
  input  logic [ADDR_W-1:0] i_fifo_addr,
  input  logic              i_fifo_empty,
  output logic              o_fifo_ren,
  output logic              o_dec_vld,
  output logic [ADDR_W-1:0] o_dec_pc,
  output logic [DATA_W-1:0] o_dec_inst,
  output logic              o_dec_err,
  input  logic              i_dec_rdy,
  output logic              o_proto_err
);
  localparam int unsigned CW = $clog2(MAX_OUTST) + 1;
  localparam int unsigned EW = entry_w(ADDR_W, DATA_W);
  state_e        state_q;
  logic [CW-1:0] outst_q, drop_q, drop_ld;
  logic          arm_q, proto_q;
  logic          pass, rsp_fire, dec_fire, buf_wr, buf_full, inc, dec, ovf, unf;
  logic [EW-1:0] head;
  assign pass = state_q == ST_PASS;
  // arm_q keeps ready low through reset; a full buffer still accepts when decode pops
  assign o_rsp_rdy = arm_q & (~pass | ~buf_full | i_dec_rdy);
  assign rsp_fire = i_rsp_vld & o_rsp_rdy;
  assign dec_fire = o_dec_vld & i_dec_rdy;
  assign buf_wr = rsp_fire & pass & ~i_fifo_empty & ~i_flush;
  assign o_fifo_ren = buf_wr;
  assign inc = i_req_fire & ~rsp_fire;
  assign dec = rsp_fire & ~i_req_fire;
  assign ovf = inc & (outst_q == CW'(MAX_OUTST));
  assign unf = dec & (outst_q == '0);
  // requests still owed to the pre-flush stream; same-cycle new request excluded
  assign drop_ld = outst_q - {{(CW-1){1'b0}}, rsp_fire & (outst_q != '0)};
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_PASS;
      outst_q <= '0;
      drop_q <= '0;
      arm_q <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      arm_q <= 1'b1;
      proto_q <= proto_q | ovf | unf | (pass & rsp_fire & i_fifo_empty);
      if (inc && !ovf) outst_q <= outst_q + CW'(1);
      else if (dec && !unf) outst_q <= outst_q - CW'(1);
      if (i_flush) begin
        drop_q <= drop_ld;
        state_q <= (drop_ld != '0) ? ST_DROP : ST_PASS;
      end else if (!pass && rsp_fire) begin
        drop_q <= drop_q - CW'(1);
        if (drop_q == CW'(1)) state_q <= ST_PASS;
      end
    end
  end
  ifu_skid_buf #(.W(EW)) u_buf (
    .clk_i  (i_clk),
    .rst_ni (i_rstn),
    .clr_i  (i_flush),
    .wr_i   (buf_wr),
    .wdata_i({i_fifo_addr, i_rsp_data, i_rsp_err}),
    .rd_i   (dec_fire),
    .rdata_o(head),
    .vld_o  (o_dec_vld),
    .full_o (buf_full)
  );
  assign o_dec_pc = head[EW-1 -: ADDR_W];
  assign o_dec_inst = head[INST_LSB +: DATA_W];
  assign o_dec_err = head[ERR_LSB];
  assign o_proto_err = proto_q;
endmodule
